// File: rtl/nmr_pulse_sequencer.sv
// Multi-shot NMR pulse sequencer: GEN -> DEAD -> ACQ -> REPDLY per shot, repeated for averaging.
// Drives the DDS generator enable/config and the active-low resets of the acquisition chain.
module nmr_pulse_sequencer #(
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned SHOT_W = 16,
    parameter int unsigned AMP_W  = 16,
    parameter int unsigned FREQ_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              soft_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              done_ack,
    input  logic [AMP_W-1:0]  cfg_amp_in,
    input  logic [FREQ_W-1:0] cfg_freq_in,
    input  logic [CNT_W-1:0]  cfg_ex_time,
    input  logic [CNT_W-1:0]  cfg_dead_time,
    input  logic [CNT_W-1:0]  cfg_acq_time,
    input  logic [CNT_W-1:0]  cfg_rep_delay,
    input  logic [SHOT_W-1:0] cfg_nb_shots,
    input  logic [31:0]       cfg_size_in,
    input  logic [31:0]       cfg_nb_smpl_in,
    output logic              rst_writer,
    output logic              rst_f,
    output logic              rst_pck,
    output logic              en_gen,
    output logic [AMP_W-1:0]  cfg_amplitude,
    output logic [FREQ_W-1:0] cfg_freq,
    output logic [31:0]       size_o,
    output logic [31:0]       nb_of_sample_o,
    output logic [SHOT_W-1:0] shot_idx,
    output logic [31:0]       sts,
    output logic [5:0]        leds
);

    localparam int unsigned STS_SHOT_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        GEN    = 3'd2,
        DEAD   = 3'd3,
        ACQ    = 3'd4,
        REPDLY = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [SHOT_W-1:0]   shot_nxt;
    logic                start_q;
    logic                done_f;
    logic                done_nxt;
    logic                aborted_f;
    logic                aborted_nxt;
    logic                cfg_err_f;
    logic                cfg_err_nxt;
    logic                busy_nxt;
    logic [CNT_W-1:0]    lat_ex;
    logic [CNT_W-1:0]    lat_dead;
    logic [CNT_W-1:0]    lat_acq;
    logic [CNT_W-1:0]    lat_rep;
    logic [SHOT_W-1:0]   lat_shots;

    logic start_edge;
    logic cfg_bad;
    logic busy_now;

    assign start_edge = start & ~start_q;
    assign cfg_bad    = (cfg_ex_time == '0) | (cfg_acq_time == '0) | (cfg_nb_shots == '0);
    assign busy_now   = (state == SETUP) | (state == GEN) | (state == DEAD) |
                        (state == ACQ) | (state == REPDLY);

    // Next-state, shot index, status flags and phase counter.
    always_comb begin
        state_nxt   = state;
        shot_nxt    = shot_idx;
        done_nxt    = done_f;
        aborted_nxt = aborted_f;
        cfg_err_nxt = cfg_err_f;
        unique case (state)
            IDLE: begin
                if (start_edge && !abort) begin
                    if (cfg_bad) begin
                        cfg_err_nxt = 1'b1;
                    end else begin
                        done_nxt    = 1'b0;
                        aborted_nxt = 1'b0;
                        cfg_err_nxt = 1'b0;
                        state_nxt   = SETUP;
                    end
                end
            end
            SETUP: begin
                shot_nxt  = '0;
                state_nxt = GEN;
            end
            GEN: begin
                if (cnt == lat_ex - CNT_W'(1))
                    state_nxt = (lat_dead == '0) ? ACQ : DEAD;
            end
            DEAD: begin
                if (cnt == lat_dead - CNT_W'(1))
                    state_nxt = ACQ;
            end
            ACQ: begin
                if (cnt == lat_acq - CNT_W'(1)) begin
                    if (shot_idx == lat_shots - SHOT_W'(1)) begin
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        shot_nxt  = shot_idx + SHOT_W'(1);
                        state_nxt = (lat_rep == '0) ? GEN : REPDLY;
                    end
                end
            end
            REPDLY: begin
                if (cnt == lat_rep - CNT_W'(1))
                    state_nxt = GEN;
            end
            DONE: begin
                if (done_ack)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Abort overrides every transition of a busy run.
        if (busy_now && abort) begin
            state_nxt   = IDLE;
            shot_nxt    = shot_idx;
            done_nxt    = done_f;
            aborted_nxt = 1'b1;
        end
        busy_nxt = (state_nxt == SETUP) | (state_nxt == GEN) | (state_nxt == DEAD) |
                   (state_nxt == ACQ) | (state_nxt == REPDLY);
        cnt_nxt = '0;
        if ((state_nxt == state) && (state inside {GEN, DEAD, ACQ, REPDLY}))
            cnt_nxt = cnt + CNT_W'(1);
    end

    // State, counters, latched configuration and Moore outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (!(rst_n && soft_rst_n)) begin
            state          <= IDLE;
            cnt            <= '0;
            shot_idx       <= '0;
            start_q        <= 1'b0;
            done_f         <= 1'b0;
            aborted_f      <= 1'b0;
            cfg_err_f      <= 1'b0;
            lat_ex         <= '0;
            lat_dead       <= '0;
            lat_acq        <= '0;
            lat_rep        <= '0;
            lat_shots      <= '0;
            cfg_amplitude  <= '0;
            cfg_freq       <= '0;
            size_o         <= '0;
            nb_of_sample_o <= '0;
            rst_writer     <= 1'b1;
            rst_f          <= 1'b1;
            rst_pck        <= 1'b1;
            en_gen         <= 1'b0;
            sts            <= '0;
            leds           <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            shot_idx   <= shot_nxt;
            start_q    <= start;
            done_f     <= done_nxt;
            aborted_f  <= aborted_nxt;
            cfg_err_f  <= cfg_err_nxt;
            if (state == SETUP && !abort) begin
                lat_ex         <= cfg_ex_time;
                lat_dead       <= cfg_dead_time;
                lat_acq        <= cfg_acq_time;
                lat_rep        <= cfg_rep_delay;
                lat_shots      <= cfg_nb_shots;
                cfg_amplitude  <= cfg_amp_in;
                cfg_freq       <= cfg_freq_in;
                size_o         <= cfg_size_in;
                nb_of_sample_o <= cfg_nb_smpl_in;
            end
            rst_writer <= (state_nxt != SETUP);
            rst_f      <= (state_nxt != SETUP);
            rst_pck    <= (state_nxt != ACQ);
            en_gen     <= (state_nxt == GEN);
            sts        <= {STS_SHOT_W'(shot_nxt), 9'd0, state_nxt,
                           cfg_err_nxt, aborted_nxt, busy_nxt, done_nxt};
            leds       <= {cfg_err_nxt, aborted_nxt, done_nxt,
                           (state_nxt == ACQ), (state_nxt == GEN), busy_nxt};
        end
    end

endmodule
